// File: rtl/stm_swapchain.sv
// stm_swapchain
//   Selects which of two STM segments drives the memory reader and manages
//   transitions between them.
//
//   Playback modes:
//     RUN    - infinite playback of the active segment.
//     FINITE - counted playback; the loop counter advances on each wrap.
//     WAIT   - a transition is pending; the old segment keeps playing.
//     HALT   - counted playback has finished; IDX_OUT holds the segment's
//              last index (CYCLE).
//
//   Transition modes: 0/3 immediate, 1 on wrap of the target segment,
//   2 once SYS_TIME reaches the requested time.
//
// Ports
//   CLK             system clock, rising edge
//   RST_N           synchronous active-low reset
//   UPDATE_SETTINGS one-cycle pulse; the REQ_* inputs are valid
//   REQ_SEGMENT     target segment
//   REQ_MODE        transition mode
//   REQ_REP         repeat count; 16'hFFFF means infinite
//   REQ_TIME        transition time for mode 2
//   SYS_TIME        free-running system time
//   IDX[]           per-segment index from the STM timer
//   CYCLE[]         last valid index of each segment
//   SEGMENT         active segment
//   IDX_OUT         index presented to the STM memory reader
//   STOP            finite playback finished
//   SWAP_DONE       one-cycle pulse on each completed transition
module stm_swapchain #(
  parameter int IdxWidth   = 13,
  parameter int NumSegment = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                UPDATE_SETTINGS,
  input  logic                REQ_SEGMENT,
  input  logic [1:0]          REQ_MODE,
  input  logic [15:0]         REQ_REP,
  input  logic [63:0]         REQ_TIME,
  input  logic [63:0]         SYS_TIME,
  input  logic [IdxWidth-1:0] IDX   [NumSegment],
  input  logic [IdxWidth-1:0] CYCLE [NumSegment],
  output logic                SEGMENT,
  output logic [IdxWidth-1:0] IDX_OUT,
  output logic                STOP,
  output logic                SWAP_DONE
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FINITE,
    ST_WAIT,
    ST_HALT
  } state_t;

  localparam logic [15:0] RepInfinite = 16'hFFFF;

  state_t              state_q, state_d;
  logic                seg_q, seg_d;
  logic [IdxWidth-1:0] idx_out_q, idx_out_d;
  logic                stop_q, stop_d;
  logic                swap_q, swap_d;
  logic                req_seg_q, req_seg_d;
  logic [1:0]          req_mode_q, req_mode_d;
  logic [15:0]         req_rep_q, req_rep_d;
  logic [63:0]         req_time_q, req_time_d;
  logic [15:0]         loop_q, loop_d;
  logic [15:0]         rep_q, rep_d;
  logic [IdxWidth-1:0] prev_q [NumSegment];
  logic [NumSegment-1:0] wrap;
  logic                exit_ok;

  // A wrap is the index moving backwards relative to the previous cycle.
  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < NumSegment; i++) begin
      wrap[i] = prev_q[i] > IDX[i];
    end
  end

  always_comb begin
    unique case (req_mode_q)
      2'd1:    exit_ok = wrap[req_seg_q];
      2'd2:    exit_ok = SYS_TIME >= req_time_q;
      default: exit_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    stop_d     = stop_q;
    swap_d     = 1'b0;
    loop_d     = loop_q;
    rep_d      = rep_q;
    req_seg_d  = req_seg_q;
    req_mode_d = req_mode_q;
    req_rep_d  = req_rep_q;
    req_time_d = req_time_q;

    // A new request always wins, including over a concurrent FINITE wrap
    // and over a pending request, which it simply replaces.
    if (UPDATE_SETTINGS) begin
      req_seg_d  = REQ_SEGMENT;
      req_mode_d = REQ_MODE;
      req_rep_d  = REQ_REP;
      req_time_d = REQ_TIME;
      state_d    = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (exit_ok) begin
            seg_d   = req_seg_q;
            loop_d  = '0;
            rep_d   = req_rep_q;
            stop_d  = 1'b0;
            swap_d  = 1'b1;
            state_d = (req_rep_q == RepInfinite) ? ST_RUN : ST_FINITE;
          end
        end
        ST_FINITE: begin
          if (wrap[seg_q]) begin
            if (loop_q == rep_q) begin
              state_d = ST_HALT;
              stop_d  = 1'b1;
            end else begin
              loop_d = loop_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Uses the pre-swap segment so playback is uninterrupted on the swap edge.
    idx_out_d = (state_d == ST_HALT) ? CYCLE[seg_q] : IDX[seg_q];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_RUN;
      seg_q      <= 1'b0;
      idx_out_q  <= '0;
      stop_q     <= 1'b0;
      swap_q     <= 1'b0;
      req_seg_q  <= 1'b0;
      req_mode_q <= '0;
      req_rep_q  <= '0;
      req_time_q <= '0;
      loop_q     <= '0;
      rep_q      <= RepInfinite;
      for (int unsigned i = 0; i < NumSegment; i++) prev_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      idx_out_q  <= idx_out_d;
      stop_q     <= stop_d;
      swap_q     <= swap_d;
      req_seg_q  <= req_seg_d;
      req_mode_q <= req_mode_d;
      req_rep_q  <= req_rep_d;
      req_time_q <= req_time_d;
      loop_q     <= loop_d;
      rep_q      <= rep_d;
      for (int unsigned i = 0; i < NumSegment; i++) prev_q[i] <= IDX[i];
    end
  end

  assign SEGMENT   = seg_q;
  assign IDX_OUT   = idx_out_q;
  assign STOP      = stop_q;
  assign SWAP_DONE = swap_q;

endmodule

// File: tb/tb_stm_swapchain.sv
module tb_stm_swapchain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd;
  logic        rseg;
  logic [1:0]  rmode;
  logic [15:0] rrep;
  logic [63:0] rtime;
  logic [63:0] systime;
  logic [12:0] idx [2];
  logic [12:0] cyc [2];
  logic        seg;
  logic [12:0] idx_out;
  logic        stop;
  logic        swap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stm_swapchain #(.IdxWidth(13), .NumSegment(2)) dut (
    .CLK(clk), .RST_N(rst_n), .UPDATE_SETTINGS(upd), .REQ_SEGMENT(rseg),
    .REQ_MODE(rmode), .REQ_REP(rrep), .REQ_TIME(rtime), .SYS_TIME(systime),
    .IDX(idx), .CYCLE(cyc), .SEGMENT(seg), .IDX_OUT(idx_out), .STOP(stop),
    .SWAP_DONE(swap)
  );

  // Behavioural model: a pending-request flag plus a "loops remaining" count.
  bit          m_seg, m_stop, m_swap, m_pend, m_pseg, m_fin, m_halt;
  logic [1:0]  m_pmode;
  logic [15:0] m_prep;
  logic [63:0] m_ptime;
  int          m_left;
  logic [12:0] m_idx_out;
  logic [12:0] m_prev [2];

  function automatic void model_step();
    bit old_seg;
    bit go;
    old_seg = m_seg;
    if (!rst_n) begin
      m_seg = 0; m_stop = 0; m_swap = 0; m_pend = 0; m_fin = 0; m_halt = 0;
      m_idx_out = '0; m_prev[0] = '0; m_prev[1] = '0;
      return;
    end
    m_swap = 0;
    if (upd) begin
      m_pend = 1; m_pseg = rseg; m_pmode = rmode; m_prep = rrep; m_ptime = rtime;
    end else if (m_pend) begin
      if (m_pmode == 2'd1)      go = m_prev[m_pseg] > idx[m_pseg];
      else if (m_pmode == 2'd2) go = systime >= m_ptime;
      else                      go = 1;
      if (go) begin
        m_pend = 0; m_seg = m_pseg; m_fin = (m_prep != 16'hFFFF);
        m_left = int'(m_prep) + 1; m_halt = 0; m_stop = 0; m_swap = 1;
      end
    end else if (m_fin && !m_halt && m_prev[old_seg] > idx[old_seg]) begin
      m_left--;
      if (m_left == 0) begin
        m_halt = 1; m_stop = 1;
      end
    end
    m_idx_out = (m_halt && !m_pend) ? cyc[m_seg] : idx[old_seg];
    m_prev[0] = idx[0];
    m_prev[1] = idx[1];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later, then
  // the pulse is cleared and time/indices advance for the next cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("segment", {63'd0, seg}, {63'd0, m_seg});
    check("idx_out", {51'd0, idx_out}, {51'd0, m_idx_out});
    check("stop", {63'd0, stop}, {63'd0, m_stop});
    check("swap_done", {63'd0, swap}, {63'd0, m_swap});
    upd = 1'b0;
    systime = systime + 64'd1;
    for (int i = 0; i < 2; i++) idx[i] = (idx[i] >= cyc[i]) ? 13'd0 : idx[i] + 13'd1;
  endtask

  task automatic request(input bit s, input logic [1:0] m, input logic [15:0] r,
                         input logic [63:0] t);
    upd = 1'b1; rseg = s; rmode = m; rrep = r; rtime = t;
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [63:0] at_time;

    rst_n = 1'b0; upd = 1'b0; rseg = 1'b0; rmode = '0; rrep = '0; rtime = '0;
    systime = '0; idx[0] = '0; idx[1] = '0; cyc[0] = 13'd9; cyc[1] = 13'd4;
    tick(); tick();
    check("rst_segment", {63'd0, seg}, 64'd0);
    check("rst_idx_out", {51'd0, idx_out}, 64'd0);
    check("rst_stop", {63'd0, stop}, 64'd0);
    check("rst_swap", {63'd0, swap}, 64'd0);
    idx[0] = '0;
    rst_n = 1'b1;

    // Ramp of segment 0: IDX_OUT lags by one cycle, never a swap.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ramp_lag", {51'd0, idx_out}, i);
      check("ramp_noswap", {63'd0, swap}, 64'd0);
    end

    // Immediate swap to segment 1: SWAP_DONE two cycles after the pulse.
    request(1'b1, 2'd0, 16'hFFFF, '0);
    tick();
    check("imm_early", {63'd0, swap}, 64'd0);
    tick();
    check("imm_swap", {63'd0, swap}, 64'd1);
    check("imm_seg", {63'd0, seg}, 64'd1);
    repeat (6) tick();

    // Timed swap at 1000, time ramping from 900.
    systime = 64'd900;
    request(1'b0, 2'd2, 16'hFFFF, 64'd1000);
    tick();
    seen = 0; at_time = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (swap) begin
        seen = 1; at_time = systime - 64'd1;
      end
    end
    check("timed_seen", {63'd0, seen}, 64'd1);
    check("timed_at", at_time, 64'd1000);
    check("timed_seg", {63'd0, seg}, 64'd0);

    // Sync swap to segment 1, three loops of five indices each.
    request(1'b1, 2'd1, 16'd2, '0);
    tick();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = swap;
    end
    check("sync_seen", {63'd0, seen}, 64'd1);
    cnt = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      cnt++;
      seen = stop;
    end
    check("finite_stop", {63'd0, seen}, 64'd1);
    check("finite_len", cnt, 64'd15);
    check("halt_idx", {51'd0, idx_out}, 64'd4);
    repeat (3) tick();
    check("halt_hold", {51'd0, idx_out}, 64'd4);
    check("halt_stop", {63'd0, stop}, 64'd1);

    // Pending timed request replaced by an immediate one.
    request(1'b1, 2'd2, 16'hFFFF, systime + 64'd100000);
    tick(); tick();
    request(1'b0, 2'd0, 16'hFFFF, '0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (swap) cnt++;
    end
    check("replace_count", cnt, 64'd1);
    check("replace_seg", {63'd0, seg}, 64'd0);

    // Reset during FINITE, with a concurrent update that must be ignored.
    request(1'b1, 2'd0, 16'd3, '0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    request(1'b1, 2'd0, 16'd0, '0);
    tick();
    check("rstfin_seg", {63'd0, seg}, 64'd0);
    check("rstfin_idx", {51'd0, idx_out}, 64'd0);
    check("rstfin_stop", {63'd0, stop}, 64'd0);
    check("rstfin_swap", {63'd0, swap}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("rstfin_after", {63'd0, swap}, 64'd0);

    // Reset during WAIT.
    request(1'b1, 2'd2, 16'd1, systime + 64'd3);
    tick();
    rst_n = 1'b0;
    tick();
    check("rstwait_seg", {63'd0, seg}, 64'd0);
    check("rstwait_swap", {63'd0, swap}, 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (swap || stop) cnt++;
    end
    check("rstwait_quiet", cnt, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        request(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3)),
                systime + 64'($urandom_range(0, 30)));
      end
      if ($urandom_range(0, 199) == 0) cyc[$urandom_range(0, 1)] = 13'($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) begin
        int s;
        s = $urandom_range(0, 1);
        idx[s] = 13'($urandom_range(0, int'(cyc[s])));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
